branch_predictor: RTL
=====================

Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline.
- Replaces static predict-not-taken with a direct-mapped BTB plus a saturating-counter pattern table, with optional gshare history.
- IF does a combinational lookup on the fetch PC. EX resolves and presents the outcome. The block updates its tables, raises the redirect/flush request and keeps performance counters.

Parameters:
- ENTRIES, 64, BTB/pattern-table entries; power of two, 4..1024; IDX_W = log2(ENTRIES).
- CTR_W, 2, saturating counter width, 1..4.
- GHR_W, 0, global history bits XORed into the index; 0 = bimodal; GHR_W <= IDX_W.
- MODE, 1, 0 = static not-taken (tables never written), 1 = dynamic.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- pred_pc  in  32  IF fetch PC.
- pred_taken  out  1  predict taken.
- pred_target  out  32  predicted target, word aligned.
- pred_idx  out  IDX_W  index used; carried down the pipe.
- stall  in  1  pipeline stall (icache or dcache).
- upd_valid  in  1  EX holds a resolved control-flow instruction.
- upd_is_br  in  1  conditional branch.
- upd_is_jump  in  1  jal/jalr.
- upd_pc  in  32  PC of the EX instruction.
- upd_idx  in  IDX_W  pred_idx captured at fetch.
- upd_taken  in  1  actual outcome (1 for jumps).
- upd_target  in  32  actual target.
- upd_pred_taken  in  1  prediction carried from IF.
- upd_pred_target  in  32  predicted target carried from IF.
- redirect  out  1  mispredict; flush IF/ID and ID/EX.
- redirect_pc  out  32  corrected PC.
- br_count  out  32  resolved control-flow instructions.
- mispred_count  out  32  mispredictions.

Behaviour:
- Fields:
  - tag = pc[31:IDX_W+2].
  - Lookup index = pc[IDX_W+1:2] XOR {zeros, ghr} when GHR_W > 0, else pc[IDX_W+1:2].
  - Entry = {valid, tag, target[31:2], is_jump} plus a CTR_W-bit counter.
- Lookup is combinational from registered arrays:
  - hit = valid && tag match.
  - pred_taken = MODE && hit && (is_jump || ctr[CTR_W-1]).
  - pred_target = {target, 2'b00} on hit, else pred_pc+4.
- No write-to-read bypass: a lookup in the update cycle sees pre-update contents.
- Update fires only when fire = upd_valid & ~stall & MODE. It is written on the next rising clk, and each resolved instruction updates exactly once however long the stall lasts.
- Conditional branch at upd_idx:
  - Counter saturating +1 if taken, -1 if not; no wrap at 0 or 2^CTR_W-1.
  - If taken: write valid=1, tag, target, is_jump=0.
  - If not taken: BTB entry unchanged.
- Jump: write valid=1, tag, target, is_jump=1; counter untouched.
- GHR, on a conditional branch when fire: ghr <= {ghr[GHR_W-2:0], upd_taken}. It is non-speculative. For GHR_W=1, ghr <= upd_taken.
- Redirect is combinational, same cycle as EX:
  - redirect = upd_valid & ~stall & rst & (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
  - redirect_pc = upd_taken ? {upd_target[31:2],2'b00} : upd_pc+4.
  - In MODE 0, redirect still operates; pred_taken is always 0.
- Counters: br_count +1 on every upd_valid & ~stall; mispred_count +1 when redirect. Both wrap at 2^32.
- Reset (rst low, immediately, asynchronously):
  - All valid = 0.
  - Counters = 2^(CTR_W-1)-1 (weakly not-taken; 0 when CTR_W=1).
  - ghr = 0; br_count = mispred_count = 0.
  - pred_taken = 0; redirect = 0.
- Reset mid-update: the update is lost and no partial entry is written.

Decomposition:
- Package bp_types:
  - bp_entry_t struct.
  - Function sat_update(ctr, taken).
  - Localparam helper for the weakly-not-taken init value.
- Sub-module bp_table: entry and counter arrays, one combinational read port, one synchronous write port, async reset. Top level holds index/GHR/redirect/counter logic.

Test Plan:
All tests use ENTRIES=64, CTR_W=2, GHR_W=0, MODE=1 unless stated.
1. Release reset, lookup pred_pc=0x60 -> pred_taken=0, pred_target=0x64, br_count=0.
2. Update branch pc=0x100, taken, target 0x80, upd_pred_taken=0 -> redirect=1, redirect_pc=0x80, mispred_count=1. Next cycle lookup 0x100 -> counter 10, pred_taken=1, pred_target=0x80.
3. Then two not-taken updates of 0x100 with upd_pred_taken=1 -> first gives redirect_pc=0x104, counter 01; second gives counter 00. Lookup 0x100 -> pred_taken=0, mispred_count=3.
4. jal pc=0x200, target 0x400 -> index 0 aliases 0x100. Lookup 0x200 -> taken to 0x400. Lookup 0x100 -> miss (tag evicted).
5. upd_valid held with stall=1 for 3 cycles, then stall=0 one cycle -> redirect only in the final cycle; br_count +1 exactly; counter changes once.
6. Assert rst low mid-stream after case 2 -> pred_taken and redirect drop at once. After release, lookup 0x100 -> pred_taken=0. Counters read 0.
7. GHR_W=2, taken branch pc=0x100 -> ghr=01. Lookup 0x100 -> pred_idx=1.

Source files
------------

// File: rtl/bp_types.sv
// Shared types and helpers for the dynamic branch predictor: BTB entry layout,
// saturating-counter update and the weakly-not-taken reset value.
package bp_types;

  // Tag field is sized for the smallest table (IDX_W = 2); narrower tags are zero-extended.
  localparam int TAG_MAX = 28;

  typedef struct packed {
    logic               valid;
    logic [TAG_MAX-1:0] tag;
    logic [29:0]        target;
    logic               is_jump;
  } bp_entry_t;

  function automatic logic [3:0] sat_update(input logic [3:0] ctr, input logic taken,
                                            input int ctr_w);
    logic [3:0] max_v;
    max_v = 4'((1 << ctr_w) - 1);
    if (taken) return (ctr == max_v) ? ctr : ctr + 4'd1;
    else       return (ctr == 4'd0)  ? ctr : ctr - 4'd1;
  endfunction

  function automatic logic [3:0] wnt_init(input int ctr_w);
    return 4'((1 << (ctr_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/bp_table.sv
// BTB + pattern table storage: one combinational read port, one synchronous
// write port; the counter update is applied in place at the write index.
module bp_table
  import bp_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int IDX_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_entry_t        rd_entry,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             we_ent,
  input  logic             we_ctr,
  input  logic [IDX_W-1:0] wr_idx,
  input  bp_entry_t        wr_entry,
  input  logic             wr_taken
);

  localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'(wnt_init(CTR_W));

  bp_entry_t        ent_q [ENTRIES];
  bp_entry_t        ent_d [ENTRIES];
  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];

  always_comb begin
    ent_d = ent_q;
    ctr_d = ctr_q;
    if (we_ent) ent_d[wr_idx] = wr_entry;
    if (we_ctr) ctr_d[wr_idx] = CTR_W'(sat_update(4'(ctr_q[wr_idx]), wr_taken, CTR_W));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ent_q[i] <= '0;
        ctr_q[i] <= CTR_INIT;
      end
    end else begin
      ent_q <= ent_d;
      ctr_q <= ctr_d;
    end
  end

  // Reads see pre-update contents; no write-to-read bypass.
  assign rd_entry = ent_q[rd_idx];
  assign rd_ctr   = ctr_q[rd_idx];

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB + saturating counters with optional gshare
// history, same-cycle redirect on mispredict and performance counters.
module branch_predictor
  import bp_types::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2,
  parameter int GHR_W   = 0,
  parameter int MODE    = 1,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             stall,
  input  logic             upd_valid,
  input  logic             upd_is_br,
  input  logic             upd_is_jump,
  input  logic [31:0]      upd_pc,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [31:0]      br_count,
  output logic [31:0]      mispred_count
);

  localparam int GW = (GHR_W > 0) ? GHR_W : 1;

  logic [GW-1:0] ghr_q, ghr_d;
  logic [31:0]   br_count_q, br_count_d, mispred_q, mispred_d;
  bp_entry_t     rd_entry, wr_entry;
  logic [CTR_W-1:0] rd_ctr;
  logic          hit, fire, resolved, we_ent, we_ctr;

  // With GHR_W = 0 the history register is never written, so it XORs in zero.
  assign pred_idx = pred_pc[IDX_W+1:2] ^ IDX_W'(ghr_q);
  assign hit      = rd_entry.valid && (rd_entry.tag == TAG_MAX'(pred_pc[31:IDX_W+2]));

  assign pred_taken  = (MODE != 0) && hit && (rd_entry.is_jump || rd_ctr[CTR_W-1]);
  assign pred_target = hit ? {rd_entry.target, 2'b00} : pred_pc + 32'd4;

  assign resolved = upd_valid & ~stall;
  assign fire     = resolved & (MODE != 0);
  assign we_ctr   = fire & upd_is_br;
  assign we_ent   = fire & (upd_is_br ? upd_taken : upd_is_jump);

  always_comb begin
    wr_entry         = '0;
    wr_entry.valid   = 1'b1;
    wr_entry.tag     = TAG_MAX'(upd_pc[31:IDX_W+2]);
    wr_entry.target  = upd_target[31:2];
    wr_entry.is_jump = ~upd_is_br;
  end

  bp_table #(.ENTRIES(ENTRIES), .CTR_W(CTR_W), .IDX_W(IDX_W)) u_table (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (pred_idx),
    .rd_entry (rd_entry),
    .rd_ctr   (rd_ctr),
    .we_ent   (we_ent),
    .we_ctr   (we_ctr),
    .wr_idx   (upd_idx),
    .wr_entry (wr_entry),
    .wr_taken (upd_taken)
  );

  assign redirect = resolved & rst &
                    ((upd_taken != upd_pred_taken) ||
                     (upd_taken && (upd_target != upd_pred_target)));
  assign redirect_pc = upd_taken ? {upd_target[31:2], 2'b00} : upd_pc + 32'd4;

  always_comb begin
    ghr_d      = ghr_q;
    br_count_d = br_count_q;
    mispred_d  = mispred_q;
    // Shift in the outcome; truncation drops the oldest bit (and handles GW = 1).
    if ((GHR_W > 0) && we_ctr) ghr_d = GW'({ghr_q, upd_taken});
    if (resolved) br_count_d = br_count_q + 32'd1;
    if (redirect) mispred_d  = mispred_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ghr_q      <= '0;
      br_count_q <= '0;
      mispred_q  <= '0;
    end else begin
      ghr_q      <= ghr_d;
      br_count_q <= br_count_d;
      mispred_q  <= mispred_d;
    end
  end

  assign br_count      = br_count_q;
  assign mispred_count = mispred_q;

endmodule
